// File: rtl/zoom_pkg.sv
// Shared widths, screen geometry and FSM encoding for the zoom expander slice.
// Purpose: common types; latency: n/a; backpressure: n/a.
// Screen geometry is only consumed when ZOOM_CLIP_EN is defined.
package zoom_pkg;

  localparam int COORD_W  = 8;
  localparam int ZOOM_W   = 8;
  localparam int OUT_W    = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CLIP = 2'd2,
    EMIT = 2'd3
  } state_t;

endpackage

// File: rtl/zoom_shift_mul.sv
// Purpose: unsigned shift-add multiplier, A_W x B_W -> P_W, started by a one-cycle start pulse.
// Latency: done pulses exactly B_W cycles after start; prod holds until the next start.
// Backpressure: none; a new start restarts the operation unconditionally.
module zoom_shift_mul #(
  parameter int A_W = zoom_pkg::COORD_W,
  parameter int B_W = zoom_pkg::ZOOM_W,
  parameter int P_W = zoom_pkg::OUT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] prod,
  output logic           done
);

  localparam int CNT_W = $clog2(B_W + 1);

  logic [P_W-1:0]   mcand;
  logic [B_W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic             run;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        prod   <= '0;
        mcand  <= P_W'(a);
        mplier <= b;
        cnt    <= CNT_W'(B_W);
        run    <= 1'b1;
      end else if (run) begin
        // One multiplier bit per cycle; P_W >= A_W+B_W so the shifted multiplicand never loses bits.
        if (mplier[0]) begin
          prod <= prod + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/zoom_expander.sv
// Purpose: expands one source pixel into its ZxZ screen footprint in raster order (ZOOM_CLIP_EN adds screen clipping).
// Latency: first beat ZOOM_W+1 cycles after accept (ZOOM_W+2 with ZOOM_CLIP_EN).
// Backpressure: valid/ready on the output holds the beat; s_ready only in IDLE, never same-cycle re-accept.
module zoom_expander #(
  parameter int COORD_W = zoom_pkg::COORD_W,
  parameter int ZOOM_W  = zoom_pkg::ZOOM_W,
  parameter int OUT_W   = zoom_pkg::OUT_W
`ifdef ZOOM_CLIP_EN
  ,
  parameter int SCREEN_W = zoom_pkg::SCREEN_W,
  parameter int SCREEN_H = zoom_pkg::SCREEN_H
`endif
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [COORD_W-1:0] Xcoord,
  input  logic [COORD_W-1:0] Ycoord,
  input  logic [ZOOM_W-1:0]  Zoom,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [OUT_W-1:0]   Xout,
  output logic [OUT_W-1:0]   Yout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy
);

  import zoom_pkg::*;

  localparam logic [ZOOM_W-1:0] Z_ONE = ZOOM_W'(1);

  state_t            state;
  logic [ZOOM_W-1:0] z_q;
  logic [ZOOM_W-1:0] zoom_eff;
  logic [ZOOM_W-1:0] ext_x, ext_y;
  logic [ZOOM_W-1:0] dx, dy, dx_n, dy_n;
  logic [OUT_W-1:0]  base_x, base_y;
  logic              done_x, done_y;
  logic              accept, row_end;

  assign zoom_eff = (Zoom == '0) ? Z_ONE : Zoom;
  assign accept   = s_valid && s_ready;
  assign busy     = (state != IDLE);

  zoom_shift_mul #(.A_W(COORD_W), .B_W(ZOOM_W), .P_W(OUT_W)) u_mul_x (
    .clk   (ACLK),
    .rst   (ARESET),
    .start (accept),
    .a     (Xcoord),
    .b     (zoom_eff),
    .prod  (base_x),
    .done  (done_x)
  );

  zoom_shift_mul #(.A_W(COORD_W), .B_W(ZOOM_W), .P_W(OUT_W)) u_mul_y (
    .clk   (ACLK),
    .rst   (ARESET),
    .start (accept),
    .a     (Ycoord),
    .b     (zoom_eff),
    .prod  (base_y),
    .done  (done_y)
  );

  // Next dx/dy position in the raster scan, dx innermost.
  always_comb begin
    row_end = (dx == ext_x - Z_ONE);
    dx_n    = row_end ? '0 : dx + Z_ONE;
    dy_n    = row_end ? dy + Z_ONE : dy;
  end

`ifdef ZOOM_CLIP_EN
  logic [ZOOM_W-1:0] clip_x, clip_y;

  function automatic logic [ZOOM_W-1:0] clip_ext(input logic [OUT_W-1:0] base,
                                                 input logic [OUT_W-1:0] limit,
                                                 input logic [ZOOM_W-1:0] z);
    logic [OUT_W-1:0] room;
    room = limit - base;
    if (base >= limit) return '0;
    if (room < OUT_W'(z)) return room[ZOOM_W-1:0];
    return z;
  endfunction

  assign clip_x = clip_ext(base_x, OUT_W'(SCREEN_W), z_q);
  assign clip_y = clip_ext(base_y, OUT_W'(SCREEN_H), z_q);
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      Xout    <= '0;
      Yout    <= '0;
      z_q     <= '0;
      ext_x   <= '0;
      ext_y   <= '0;
      dx      <= '0;
      dy      <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            z_q     <= zoom_eff;
            s_ready <= 1'b0;
            state   <= MUL;
          end
        end
        MUL: begin
          if (done_x && done_y) begin
`ifdef ZOOM_CLIP_EN
            state <= CLIP;
`else
            state   <= EMIT;
            ext_x   <= z_q;
            ext_y   <= z_q;
            dx      <= '0;
            dy      <= '0;
            Xout    <= base_x;
            Yout    <= base_y;
            m_valid <= 1'b1;
            m_last  <= (z_q == Z_ONE);
`endif
          end
        end
`ifdef ZOOM_CLIP_EN
        CLIP: begin
          if (clip_x == '0 || clip_y == '0) begin
            // Footprint entirely off-screen: nothing to emit.
            state   <= IDLE;
            s_ready <= 1'b1;
          end else begin
            state   <= EMIT;
            ext_x   <= clip_x;
            ext_y   <= clip_y;
            dx      <= '0;
            dy      <= '0;
            Xout    <= base_x;
            Yout    <= base_y;
            m_valid <= 1'b1;
            m_last  <= (clip_x == Z_ONE) && (clip_y == Z_ONE);
          end
        end
`endif
        EMIT: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              s_ready <= 1'b1;
              state   <= IDLE;
            end else begin
              dx     <= dx_n;
              dy     <= dy_n;
              Xout   <= row_end ? base_x : Xout + OUT_W'(1);
              Yout   <= row_end ? Yout + OUT_W'(1) : Yout;
              m_last <= (dx_n == ext_x - Z_ONE) && (dy_n == ext_y - Z_ONE);
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
